// File: rtl/imem_loader_ctrl.sv
// Boot loader: receives a framed program over the UART byte stream, writes it into
// instruction memory and releases the CPU once the checksum matches.
module imem_loader_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_WORDS      = 1024,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        reload_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        cpu_run,
  output logic        load_busy,
  output logic        load_err,
  output logic [15:0] word_count
);
  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]    MAXW     = 17'(MAX_WORDS);

  typedef enum logic [3:0] {IDLE, CNT_L, CNT_H, DAT_L, DAT_H, CSUM, DONE, RUN, ERR} state_t;

  state_t        state, nxt;
  logic [15:0]   cnt;
  logic [7:0]    lsb;
  logic [7:0]    sum;
  logic [TW-1:0] tmo;
  logic          busy, tmo_hit, take;
  logic [15:0]   n_rx;

  assign n_rx    = {rx_data, lsb};
  assign busy    = state inside {CNT_L, CNT_H, DAT_L, DAT_H, CSUM};
  assign tmo_hit = busy && !rx_valid && (tmo == TMO_LAST);
  assign take    = reload_n && rx_valid;

  always_comb begin
    nxt = state;
    if (!reload_n) nxt = IDLE;
    else begin
      case (state)
        IDLE:  if (rx_valid && rx_data == SYNC_BYTE) nxt = CNT_L;
        CNT_L: if (rx_valid) nxt = CNT_H;
        CNT_H: if (rx_valid) begin
                 if ({1'b0, n_rx} > MAXW) nxt = ERR;
                 else if (n_rx == 16'd0)  nxt = CSUM;
                 else                     nxt = DAT_L;
               end
        DAT_L: if (rx_valid) nxt = DAT_H;
        // imem_addr already holds the index of the word being completed here
        DAT_H: if (rx_valid) nxt = (imem_addr == cnt - 16'd1) ? CSUM : DAT_L;
        CSUM:  if (rx_valid) nxt = (rx_data == sum) ? DONE : ERR;
        DONE:  nxt = RUN;
        RUN:   nxt = RUN;
        ERR:   nxt = ERR;
        default: nxt = IDLE;
      endcase
      if (tmo_hit) nxt = ERR;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      cpu_hold   <= 1'b1;
      cpu_run    <= 1'b0;
      load_busy  <= 1'b0;
      load_err   <= 1'b0;
      sum        <= '0;
      tmo        <= '0;
      cnt        <= '0;
      lsb        <= '0;
    end else begin
      state     <= nxt;
      cpu_hold  <= !(nxt inside {DONE, RUN});
      cpu_run   <= (nxt == RUN);
      load_busy <= nxt inside {CNT_L, CNT_H, DAT_L, DAT_H, CSUM};
      load_err  <= (nxt == ERR);
      imem_we   <= take && (state == DAT_H);

      // a write that has already gone out is always accounted for, even if aborted next
      if (imem_we) begin
        imem_addr  <= imem_addr + 16'd1;
        word_count <= word_count + 16'd1;
      end

      if (!reload_n || !busy || rx_valid || tmo_hit) tmo <= '0;
      else                                          tmo <= tmo + TW'(1);

      if (take) begin
        case (state)
          CNT_L: lsb <= rx_data;
          CNT_H: begin
            cnt        <= n_rx;
            imem_addr  <= '0;
            word_count <= '0;
            sum        <= '0;
          end
          DAT_L: begin
            lsb <= rx_data;
            sum <= sum + rx_data;
          end
          DAT_H: begin
            imem_wdata <= n_rx;
            sum        <= sum + rx_data;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Randomized frame bench for imem_loader_ctrl, checked against a byte-stream parser model.
module tb_imem_loader_ctrl;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXW = 1024;
  localparam int TMO  = 50;
  localparam int O_BUSY = 0, O_RUN = 1, O_ERR = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        reload_n = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        imem_we, cpu_hold, cpu_run, load_busy, load_err;
  logic [15:0] imem_addr, imem_wdata, word_count;

  imem_loader_ctrl #(.SYNC_BYTE(SYNC), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .reload_n(reload_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .cpu_run(cpu_run), .load_busy(load_busy), .load_err(load_err), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  logic [7:0]  frame[$];
  logic [31:0] exp_w[$];
  logic [31:0] obs[$];
  int          done_cyc;
  logic [15:0] exp_wc = '0;

  always @(negedge CLK) begin
    if (imem_we) obs.push_back({imem_addr, imem_wdata});
    if (!cpu_hold && !cpu_run) done_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0; rx_data = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic pulse_reload();
    reload_n = 1'b0;
    tick();
    reload_n = 1'b1;
  endtask

  // Parses the byte stream the way the frame format defines it.
  task automatic model(output int outc);
    int i, sz, n, s;
    sz = frame.size(); i = 0; outc = O_BUSY; exp_w.delete();
    while (i < sz && frame[i] != SYNC) i++;
    i++;
    if (i + 1 < sz) begin
      n = {frame[i+1], frame[i]}; i += 2;
      exp_wc = '0;
      if (n > MAXW) outc = O_ERR;
      else begin
        s = 0;
        for (int k = 0; k < n && i + 1 < sz; k++) begin
          exp_w.push_back({16'(k), frame[i+1], frame[i]});
          s = (s + frame[i] + frame[i+1]) % 256;
          exp_wc++; i += 2;
        end
        if (int'(exp_wc) == n && i < sz) outc = (int'(frame[i]) == s) ? O_RUN : O_ERR;
      end
    end
  endtask

  task automatic run_frame(input string tag);
    int outc;
    pulse_reload();
    obs.delete(); done_cyc = 0;
    foreach (frame[i]) send(frame[i], $urandom_range(0, 3));
    repeat (4) tick();
    model(outc);
    chk({tag, ".nwr"}, obs.size(), exp_w.size());
    foreach (exp_w[k]) if (k < obs.size()) chk({tag, ".wr"}, obs[k], exp_w[k]);
    chk({tag, ".wc"},   word_count, exp_wc);
    chk({tag, ".run"},  cpu_run, outc == O_RUN);
    chk({tag, ".hold"}, cpu_hold, outc != O_RUN);
    chk({tag, ".err"},  load_err, outc == O_ERR);
    chk({tag, ".busy"}, load_busy, outc == O_BUSY);
    chk({tag, ".done"}, done_cyc, outc == O_RUN);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".we"},   imem_we, 0);
    chk({tag, ".addr"}, imem_addr, 0);
    chk({tag, ".wd"},   imem_wdata, 0);
    chk({tag, ".wc"},   word_count, 0);
    chk({tag, ".hold"}, cpu_hold, 1);
    chk({tag, ".run"},  cpu_run, 0);
    chk({tag, ".busy"}, load_busy, 0);
    chk({tag, ".err"},  load_err, 0);
  endtask

  initial begin
    int n, s;
    logic [7:0] b, lo, hi, cs;
    repeat (3) tick();
    chk_reset_vals("rst");
    RESET = 1'b1;
    tick();

    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h5C};
    run_frame("two_words");
    frame = '{8'hA5, 8'h01, 8'h00, 8'h34, 8'h12, 8'h00};
    run_frame("bad_csum");
    frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("empty");
    frame = '{8'hA5, 8'h01, 8'h04};
    run_frame("oversize");
    frame = '{8'hA5, 8'h00, 8'h04};
    run_frame("max_len_hdr");

    for (int t = 0; t < 25; t++) begin
      frame.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        frame.push_back(b);
      end
      frame.push_back(SYNC);
      if ($urandom_range(0, 5) == 0) begin
        n = MAXW + 1 + $urandom_range(0, 3000);
        frame.push_back(8'(n)); frame.push_back(8'(n >> 8));
      end else begin
        n = $urandom_range(0, 8); s = 0;
        frame.push_back(8'(n)); frame.push_back(8'(n >> 8));
        for (int k = 0; k < n; k++) begin
          lo = 8'($urandom); hi = 8'($urandom);
          frame.push_back(lo); frame.push_back(hi);
          s = s + lo + hi;
        end
        cs = 8'(s);
        if ($urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
        frame.push_back(cs);
      end
      run_frame("rnd");
    end

    // idle timeout inside a frame
    pulse_reload();
    obs.delete();
    send(8'hA5, 0); send(8'h03, 0); send(8'h00, 0); send(8'h11, 0);
    repeat (TMO - 1) tick();
    chk("tmo.busy", load_busy, 1);
    chk("tmo.err0", load_err, 0);
    tick();
    chk("tmo.err1", load_err, 1);
    chk("tmo.hold", cpu_hold, 1);
    chk("tmo.nwr", obs.size(), 0);
    pulse_reload();
    chk("tmo.rld_err", load_err, 0);
    chk("tmo.rld_busy", load_busy, 0);
    chk("tmo.rld_hold", cpu_hold, 1);

    // reload out of RUN, then async reset in the middle of a word
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h5C};
    run_frame("pre_rst");
    pulse_reload();
    chk("rl.hold", cpu_hold, 1);
    chk("rl.run", cpu_run, 0);
    obs.delete();
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0); send(8'h11, 0);
    rx_valid = 1'b1; rx_data = 8'h22;
    #2 RESET = 1'b0;
    #1 chk_reset_vals("arst");
    tick();
    rx_valid = 1'b0;
    repeat (2) tick();
    chk_reset_vals("arst2");
    chk("arst.nwr", obs.size(), 0);
    RESET = 1'b1;
    exp_wc = '0;
    tick();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h5C};
    run_frame("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/imem_loader_ctrl.md
IMEM_LOADER_CTRL -- requirements
Module: imem_loader_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, largest accepted program length in words.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500000, maximum idle CLK cycles between bytes inside a frame.
REQ-004 SHALL have one clock and one reset: CLK, input, 1 bit, system clock, rising edge; RESET, input, 1 bit, asynchronous, active-low.
REQ-005 SHALL have port reload_n, input, 1 bit, synchronous active-low reload request.
REQ-006 SHALL have port rx_data, input, 8 bits, UART byte.
REQ-007 SHALL have port rx_valid, input, 1 bit, one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port imem_we, output, 1 bit, instruction memory write strobe.
REQ-009 SHALL have port imem_addr, output, 16 bits, instruction memory word address.
REQ-010 SHALL have port imem_wdata, output, 16 bits, instruction word.
REQ-011 SHALL have port cpu_hold, output, 1 bit, 1 = CPU core held in reset.
REQ-012 SHALL have port cpu_run, output, 1 bit, 1 = PC/register/memory writes enabled.
REQ-013 SHALL have port load_busy, output, 1 bit, 1 = frame reception in progress.
REQ-014 SHALL have port load_err, output, 1 bit, 1 = last frame rejected.
REQ-015 SHALL have port word_count, output, 16 bits, number of words written in the current or last frame.

Function
REQ-016 SHALL implement states IDLE, CNT_L, CNT_H, DAT_L, DAT_H, CSUM, DONE, RUN, ERR.
REQ-017 SHALL accept the frame SYNC_BYTE, count LSB, count MSB, N x (word LSB, word MSB), checksum byte.
REQ-018 SHALL stay in IDLE when rx_valid with rx_data != SYNC_BYTE, and go to CNT_L on rx_data == SYNC_BYTE.
REQ-019 SHALL go CNT_L->CNT_H on rx_valid, latching the LSB.
REQ-020 SHALL, on rx_valid in CNT_H with count N: go to ERR if N > MAX_WORDS, to CSUM if N == 0, otherwise to DAT_L; each case clears imem_addr, word_count and the running sum.
REQ-021 SHALL go DAT_L->DAT_H on rx_valid, latching the LSB.
REQ-022 SHALL, on rx_valid in DAT_H, set imem_we high for exactly the next cycle, with imem_wdata = {MSB, LSB} and imem_addr = current word index.
REQ-023 SHALL increment imem_addr and word_count by 1 in the cycle after each write.
REQ-024 SHALL go from DAT_H to CSUM after word N, otherwise back to DAT_L.
REQ-025 SHALL keep the checksum as the 8-bit sum, modulo 256, of all 2N data bytes; sync and count bytes are excluded.
REQ-026 SHALL, on rx_valid in CSUM, go to DONE when the byte equals the sum and to ERR otherwise.
REQ-027 SHALL hold DONE for exactly one cycle and then go to RUN.
REQ-028 SHALL drive cpu_hold = 0 in DONE and RUN and 1 in all other states.
REQ-029 SHALL drive cpu_run = 1 only in RUN, so the CPU leaves reset one cycle before fetching.
REQ-030 SHALL drive load_busy = 1 in CNT_L, CNT_H, DAT_L, DAT_H and CSUM.
REQ-031 SHALL count idle cycles in the load_busy states, clear the count on each rx_valid, and go to ERR when it reaches TIMEOUT_CYCLES.
REQ-032 SHALL drive load_err = 1 in ERR only; ERR exits only via reload_n or RESET.
REQ-033 SHALL ignore rx_valid in DONE, RUN and ERR.
REQ-034 SHALL, when reload_n is sampled low in any state, go to IDLE next cycle with load_err cleared; reload_n has priority over rx_valid and a frame in progress is aborted.
REQ-035 SHALL never assert imem_we outside the cycle defined in REQ-022, including during an abort or an error.
REQ-036 SHALL keep the already written words in memory after an abort or error; word_count holds its value until the next count-MSB byte.

Reset
REQ-037 SHALL, on RESET low, immediately force state IDLE, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, cpu_hold=1, cpu_run=0, load_busy=0, load_err=0, sum=0 and timeout counter=0.
REQ-038 SHALL apply REQ-037 also when RESET asserts mid-frame, with no further write strobe.

Verification
REQ-039 Bytes A5,02,00,13,00,37,12,5C -> writes 0x0013@0 and 0x1237@1; DONE for 1 cycle; then cpu_run=1; word_count=2.
REQ-040 Bytes A5,01,00,34,12,00 (sum 0x46) -> one write 0x1234@0, then ERR, load_err=1, cpu_hold=1.
REQ-041 Bytes 00,FF,A5,00,00,00 -> leading bytes ignored, no write, DONE then RUN, word_count=0.
REQ-042 Bytes A5,01,04 (count 1025) -> ERR after the count MSB, with no write.
REQ-043 Bytes A5,03,00,11, then TIMEOUT_CYCLES idle cycles -> ERR; then reload_n low for 1 cycle -> IDLE, load_err=0.
REQ-044 In RUN, pulse reload_n, then RESET low mid-DAT_H -> IDLE, cpu_hold=1, all outputs at reset values, no imem_we.
